// File: rtl/csr_mmode_unit.sv
// Machine-mode CSR file with trap/mret sequencer for a single-hart core.
// Traps and mret redirect fetch through a registered one-cycle pulse.
module csr_mmode_unit #(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] HARTID      = '0,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0,
  parameter bit              VECTORED_EN = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_inst_valid,
  input  logic [XLEN-1:0] i_inst_addr,
  input  logic [1:0]      i_csr_op,
  input  logic [11:0]     i_csr_index,
  input  logic [XLEN-1:0] i_csr_wsrc,
  input  logic            i_exc_valid,
  input  logic [3:0]      i_exc_cause,
  input  logic [XLEN-1:0] i_exc_tval,
  input  logic            i_inst_mret,
  input  logic            i_irq_msip,
  input  logic            i_irq_mtip,
  input  logic            i_irq_meip,
  output logic [XLEN-1:0] o_csr_rdata,
  output logic            o_csr_illegal,
  output logic            o_redirect_valid,
  output logic [XLEN-1:0] o_redirect_pc
);
  localparam logic [11:0] A_MSTATUS = 12'h300, A_MISA = 12'h301, A_MIE = 12'h304,
                          A_MTVEC = 12'h305, A_MCOUNTINH = 12'h320, A_MSCRATCH = 12'h340,
                          A_MEPC = 12'h341, A_MCAUSE = 12'h342, A_MTVAL = 12'h343,
                          A_MIP = 12'h344, A_MCYCLE = 12'hB00, A_MINSTRET = 12'hB02,
                          A_MCYCLEH = 12'hB80, A_MINSTRETH = 12'hB82, A_MVENDORID = 12'hF11,
                          A_MARCHID = 12'hF12, A_MIMPID = 12'hF13, A_MHARTID = 12'hF14;
  localparam logic [1:0]      MXL  = (XLEN == 64) ? 2'd2 : 2'd1;
  localparam logic [XLEN-1:0] MISA = {MXL, {(XLEN-11){1'b0}}, 1'b1, 8'h00};

  typedef enum logic {S_RUN, S_REDIRECT} state_t;
  state_t r_state, w_state_nxt;

  logic            r_mie_b, r_mpie, r_mtvec_mode, r_cy_inh, r_ir_inh;
  logic [XLEN-1:2] r_mtvec_base;
  logic [XLEN-1:0] r_mepc, r_mcause, r_mtval, r_mscratch;
  logic [2:0]      r_mip, r_mie_en;   // {MEI, MTI, MSI}
  logic [63:0]     r_mcycle, r_minstret;

  logic [XLEN-1:0] w_wdata, w_trap_cause, w_trap_tval, w_trap_pc, w_mtvec_base;
  logic [2:0]      w_irq_pend;
  logic [3:0]      w_irq_code;
  logic            w_impl, w_is_wr, w_fire, w_take_irq, w_take_exc, w_trap, w_mret;
  logic            w_retire, w_csr_we;

  always_comb begin
    o_csr_rdata = '0;
    w_impl      = 1'b1;
    case (i_csr_index)
      A_MSTATUS:   begin o_csr_rdata[12:11] = 2'b11; o_csr_rdata[7] = r_mpie; o_csr_rdata[3] = r_mie_b; end
      A_MISA:      o_csr_rdata = MISA;
      A_MVENDORID, A_MARCHID, A_MIMPID: o_csr_rdata = '0;
      A_MHARTID:   o_csr_rdata = HARTID;
      A_MTVEC:     o_csr_rdata = {r_mtvec_base, 1'b0, r_mtvec_mode};
      A_MEPC:      o_csr_rdata = r_mepc;
      A_MCAUSE:    o_csr_rdata = r_mcause;
      A_MTVAL:     o_csr_rdata = r_mtval;
      A_MSCRATCH:  o_csr_rdata = r_mscratch;
      A_MIP:       begin o_csr_rdata[11] = r_mip[2]; o_csr_rdata[7] = r_mip[1]; o_csr_rdata[3] = r_mip[0]; end
      A_MIE:       begin o_csr_rdata[11] = r_mie_en[2]; o_csr_rdata[7] = r_mie_en[1]; o_csr_rdata[3] = r_mie_en[0]; end
      A_MCOUNTINH: begin o_csr_rdata[2] = r_ir_inh; o_csr_rdata[0] = r_cy_inh; end
      A_MCYCLE:    o_csr_rdata = r_mcycle[XLEN-1:0];
      A_MINSTRET:  o_csr_rdata = r_minstret[XLEN-1:0];
      A_MCYCLEH:   if (XLEN == 32) o_csr_rdata = XLEN'(r_mcycle[63:32]); else w_impl = 1'b0;
      A_MINSTRETH: if (XLEN == 32) o_csr_rdata = XLEN'(r_minstret[63:32]); else w_impl = 1'b0;
      default:     w_impl = 1'b0;
    endcase
  end

  // RS/RC with a zero operand are pure reads, so read-only CSRs stay accessible
  assign w_is_wr       = (i_csr_op == 2'b01) || (i_csr_op[1] && (i_csr_wsrc != '0));
  assign o_csr_illegal = (i_csr_op != 2'b00) && (!w_impl || (w_is_wr && (i_csr_index[11:10] == 2'b11)));

  always_comb begin
    case (i_csr_op)
      2'b10:   w_wdata = o_csr_rdata | i_csr_wsrc;
      2'b11:   w_wdata = o_csr_rdata & ~i_csr_wsrc;
      default: w_wdata = i_csr_wsrc;
    endcase
  end

  assign w_fire     = i_inst_valid && (r_state == S_RUN);
  assign w_irq_pend = r_mip & r_mie_en;
  assign w_take_irq = r_mie_b && (w_irq_pend != 3'b000);
  assign w_irq_code = w_irq_pend[2] ? 4'd11 : (w_irq_pend[0] ? 4'd3 : 4'd7);
  assign w_take_exc = i_exc_valid || o_csr_illegal;
  assign w_trap     = w_fire && (w_take_irq || w_take_exc);
  assign w_retire   = w_fire && !w_trap;
  assign w_mret     = w_retire && i_inst_mret;
  assign w_csr_we   = w_retire && !i_inst_mret && w_is_wr;

  assign w_mtvec_base = {r_mtvec_base, 2'b00};
  always_comb begin
    w_trap_cause            = '0;
    w_trap_cause[XLEN-1]    = w_take_irq;
    w_trap_cause[3:0]       = w_take_irq ? w_irq_code : (i_exc_valid ? i_exc_cause : 4'd2);
    w_trap_tval             = (!w_take_irq && i_exc_valid) ? i_exc_tval : '0;
    w_trap_pc               = w_mtvec_base;
    if (r_mtvec_mode && w_take_irq) w_trap_pc = w_mtvec_base + XLEN'({w_irq_code, 2'b00});
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:      if (w_trap || w_mret) w_state_nxt = S_REDIRECT;
      S_REDIRECT: w_state_nxt = S_RUN;
      default:    w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_RUN;
    else       r_state <= w_state_nxt;
  end

  assign o_redirect_valid = (r_state == S_REDIRECT);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mie_b       <= 1'b0;
      r_mpie        <= 1'b0;
      r_mtvec_base  <= MTVEC_RESET[XLEN-1:2];
      r_mtvec_mode  <= VECTORED_EN && MTVEC_RESET[0];
      r_mepc        <= '0;
      r_mcause      <= '0;
      r_mtval       <= '0;
      r_mscratch    <= '0;
      r_mip         <= '0;
      r_mie_en      <= '0;
      r_cy_inh      <= 1'b0;
      r_ir_inh      <= 1'b0;
      o_redirect_pc <= '0;
    end else begin
      r_mip <= {i_irq_meip, i_irq_mtip, i_irq_msip};
      if (w_trap) begin
        r_mpie        <= r_mie_b;
        r_mie_b       <= 1'b0;
        r_mepc        <= i_inst_addr & ~XLEN'(3);
        r_mcause      <= w_trap_cause;
        r_mtval       <= w_trap_tval;
        o_redirect_pc <= w_trap_pc;
      end else if (w_mret) begin
        r_mie_b       <= r_mpie;
        r_mpie        <= 1'b1;
        o_redirect_pc <= r_mepc;
      end else if (w_csr_we) begin
        case (i_csr_index)
          A_MSTATUS:   begin r_mie_b <= w_wdata[3]; r_mpie <= w_wdata[7]; end
          A_MTVEC:     begin r_mtvec_base <= w_wdata[XLEN-1:2]; r_mtvec_mode <= VECTORED_EN && w_wdata[0]; end
          A_MEPC:      r_mepc <= w_wdata & ~XLEN'(3);
          A_MCAUSE:    r_mcause <= w_wdata;
          A_MTVAL:     r_mtval <= w_wdata;
          A_MSCRATCH:  r_mscratch <= w_wdata;
          A_MIE:       r_mie_en <= {w_wdata[11], w_wdata[7], w_wdata[3]};
          A_MCOUNTINH: begin r_ir_inh <= w_wdata[2]; r_cy_inh <= w_wdata[0]; end
          default: ;
        endcase
      end
    end
  end

  // A software write to either half of a counter suppresses that cycle's increment
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      if (w_csr_we && (i_csr_index == A_MCYCLE || i_csr_index == A_MCYCLEH)) begin
        if (i_csr_index == A_MCYCLE) r_mcycle[XLEN-1:0] <= w_wdata;
        else                         r_mcycle[63:32]    <= w_wdata[31:0];
      end else if (!r_cy_inh) begin
        r_mcycle <= r_mcycle + 64'd1;
      end
      if (w_csr_we && (i_csr_index == A_MINSTRET || i_csr_index == A_MINSTRETH)) begin
        if (i_csr_index == A_MINSTRET) r_minstret[XLEN-1:0] <= w_wdata;
        else                           r_minstret[63:32]    <= w_wdata[31:0];
      end else if (w_retire && !r_ir_inh) begin
        r_minstret <= r_minstret + 64'd1;
      end
    end
  end
endmodule

// File: tb/tb_csr_mmode_unit.sv
// Directed bench: XLEN=64 and XLEN=32 instances share stimulus; each check targets one or both.
module tb_csr_mmode_unit;
  logic        gclk = 1'b0, rst = 1'b1;
  logic        inst_valid = 0, exc_valid = 0, inst_mret = 0;
  logic        msip = 0, mtip = 0, meip = 0;
  logic [1:0]  csr_op = 0;
  logic [11:0] csr_index = 0;
  logic [3:0]  exc_cause = 0;
  logic [63:0] inst_addr = 0, csr_wsrc = 0, exc_tval = 0;
  logic [63:0] rd64, rpc64;
  logic [31:0] rd32, rpc32;
  logic        ill64, ill32, rv64, rv32, ill64_q, ill32_q;
  int          n_chk = 0, n_fail = 0;

  always #5 gclk = ~gclk;

  csr_mmode_unit #(.XLEN(64)) u_dut64 (
    .i_clk(gclk), .i_rst(rst), .i_inst_valid(inst_valid), .i_inst_addr(inst_addr),
    .i_csr_op(csr_op), .i_csr_index(csr_index), .i_csr_wsrc(csr_wsrc),
    .i_exc_valid(exc_valid), .i_exc_cause(exc_cause), .i_exc_tval(exc_tval),
    .i_inst_mret(inst_mret), .i_irq_msip(msip), .i_irq_mtip(mtip), .i_irq_meip(meip),
    .o_csr_rdata(rd64), .o_csr_illegal(ill64), .o_redirect_valid(rv64), .o_redirect_pc(rpc64));

  csr_mmode_unit #(.XLEN(32)) u_dut32 (
    .i_clk(gclk), .i_rst(rst), .i_inst_valid(inst_valid), .i_inst_addr(inst_addr[31:0]),
    .i_csr_op(csr_op), .i_csr_index(csr_index), .i_csr_wsrc(csr_wsrc[31:0]),
    .i_exc_valid(exc_valid), .i_exc_cause(exc_cause), .i_exc_tval(exc_tval[31:0]),
    .i_inst_mret(inst_mret), .i_irq_msip(msip), .i_irq_mtip(mtip), .i_irq_meip(meip),
    .o_csr_rdata(rd32), .o_csr_illegal(ill32), .o_redirect_valid(rv32), .o_redirect_pc(rpc32));

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge gclk); #1;
  endtask

  task automatic rd(input logic [11:0] idx);
    csr_op = 2'b10; csr_index = idx; csr_wsrc = '0; #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [11:0] idx, input logic [63:0] src,
                       input logic [63:0] addr, input logic exc, input logic [3:0] cause,
                       input logic [63:0] tval, input logic mret);
    inst_valid = 1; csr_op = op; csr_index = idx; csr_wsrc = src; inst_addr = addr;
    exc_valid = exc; exc_cause = cause; exc_tval = tval; inst_mret = mret;
    #1; ill64_q = ill64; ill32_q = ill32;
    step();
    inst_valid = 0; csr_op = 0; exc_valid = 0; inst_mret = 0;
  endtask

  task automatic wr(input logic [11:0] idx, input logic [63:0] src);
    issue(2'b01, idx, src, 64'h100, 1'b0, 4'd0, 64'd0, 1'b0);
  endtask
  task automatic rs(input logic [11:0] idx, input logic [63:0] src);
    issue(2'b10, idx, src, 64'h100, 1'b0, 4'd0, 64'd0, 1'b0);
  endtask
  task automatic nop(input logic [63:0] addr);
    issue(2'b00, 12'h000, 64'd0, addr, 1'b0, 4'd0, 64'd0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // 1: reset then 10 idle cycles
    @(posedge gclk); #1; rst = 0;
    repeat (10) step();
    rd(12'hB00); chk("rst_mcycle64", rd64, 64'd10); chk("rst_mcycle32", 64'(rd32), 64'd10);
    rd(12'hB02); chk("rst_minstret", rd64, 64'd0);
    rd(12'h300); chk("rst_mstatus64", rd64, 64'h1800); chk("rst_mstatus32", 64'(rd32), 64'h1800);
    chk("rst_rv", 64'(rv64), 64'd0);
    step();

    // 2: vectored timer interrupt
    wr(12'h305, 64'h8000_0001);
    rd(12'h305); chk("mtvec64", rd64, 64'h8000_0001);
    rs(12'h304, 64'h80);
    rs(12'h300, 64'h8);
    rd(12'h300); chk("mstatus_mie", rd64, 64'h1808);
    mtip = 1; step();
    rd(12'h344); chk("mip_mtip", rd64, 64'h80);
    nop(64'h2000);
    chk("irq_rv", 64'(rv64), 64'd1); chk("irq_rpc64", rpc64, 64'h8000_001C);
    chk("irq_rpc32", 64'(rpc32), 64'h8000_001C);
    mtip = 0;
    rd(12'h342); chk("irq_mcause64", rd64, 64'h8000_0000_0000_0007);
    chk("irq_mcause32", 64'(rd32), 64'h8000_0007);
    rd(12'h341); chk("irq_mepc", rd64, 64'h2000);
    rd(12'h343); chk("irq_mtval", rd64, 64'd0);
    rd(12'h300); chk("irq_mstatus", rd64, 64'h1880);
    step();
    chk("redir_pulse_end", 64'(rv64), 64'd0); chk("rpc_hold", rpc64, 64'h8000_001C);

    // 3: external interrupt beats a simultaneous ecall; then mret
    rs(12'h300, 64'h8);
    rs(12'h304, 64'h800);
    meip = 1; step();
    issue(2'b00, 12'h000, 64'd0, 64'h3000, 1'b1, 4'd11, 64'hDEAD, 1'b0);
    chk("mei_rv", 64'(rv64), 64'd1); chk("mei_rpc", rpc64, 64'h8000_002C);
    meip = 0;
    rd(12'h342); chk("mei_mcause", rd64, 64'h8000_0000_0000_000B);
    rd(12'h343); chk("mei_mtval", rd64, 64'd0);
    rd(12'h341); chk("mei_mepc", rd64, 64'h3000);
    rd(12'h300); chk("mei_mstatus", rd64, 64'h1880);
    step();
    rd(12'hB02); chk("minstret_pre_mret", rd64, 64'd5);
    issue(2'b00, 12'h000, 64'd0, 64'h3004, 1'b0, 4'd0, 64'd0, 1'b1);
    chk("mret_rv", 64'(rv64), 64'd1); chk("mret_rpc", rpc64, 64'h3000);
    rd(12'h300); chk("mret_mstatus", rd64, 64'h1888);
    rd(12'hB02); chk("mret_minstret", rd64, 64'd6);
    step();

    // plain exception goes to the mtvec base even in vectored mode
    issue(2'b00, 12'h000, 64'd0, 64'h4000, 1'b1, 4'd11, 64'h55, 1'b0);
    chk("exc_rpc", rpc64, 64'h8000_0000);
    rd(12'h342); chk("exc_mcause", rd64, 64'd11);
    rd(12'h343); chk("exc_mtval", rd64, 64'h55);
    rd(12'h300); chk("exc_mstatus", rd64, 64'h1880);
    step();

    // 4: illegal accesses
    wr(12'hF14, 64'h1234);
    chk("ill_wr_ro64", 64'(ill64_q), 64'd1); chk("ill_wr_ro32", 64'(ill32_q), 64'd1);
    rd(12'h342); chk("ill_mcause", rd64, 64'd2);
    rd(12'h343); chk("ill_mtval", rd64, 64'd0);
    rd(12'hF14); chk("mhartid_unchanged", rd64, 64'd0); chk("mhartid_rd_legal", 64'(ill64), 64'd0);
    step();
    rs(12'h7C0, 64'd0);
    chk("ill_unimpl", 64'(ill64_q), 64'd1);
    rd(12'h342); chk("ill2_mcause", rd64, 64'd2);
    rd(12'hB02); chk("ill_minstret", rd64, 64'd6);
    rd(12'hB80); chk("mcycleh_ill64", 64'(ill64), 64'd1); chk("mcycleh_ok32", 64'(ill32), 64'd0);
    step();

    // 5: 32-bit counter carry, then inhibit
    wr(12'hB00, 64'hFFFF_FFFF);
    wr(12'hB80, 64'd0);
    step();
    rd(12'hB80); chk("mcycleh_carry", 64'(rd32), 64'd1);
    rd(12'hB00); chk("mcycle_lo_wrap", 64'(rd32), 64'd0);
    wr(12'h320, 64'h5);
    rd(12'h320); chk("mcountinhibit", rd64, 64'h5);
    repeat (20) nop(64'h6000);
    rd(12'hB00); chk("inh_mcycle32", 64'(rd32), 64'd1);
    rd(12'hB80); chk("inh_mcycleh32", 64'(rd32), 64'd1);
    rd(12'hB02); chk("inh_minstret32", 64'(rd32), 64'd9); chk("inh_minstret64", rd64, 64'd8);
    rd(12'hB00); chk("inh_mcycle64", rd64, 64'h1_0000_0002);
    wr(12'h320, 64'd0);
    nop(64'h6004);
    rd(12'hB02); chk("uninh_minstret32", 64'(rd32), 64'd10);

    // 6: reset while in REDIRECT
    issue(2'b00, 12'h000, 64'd0, 64'h7000, 1'b1, 4'd11, 64'd0, 1'b0);
    chk("pre_rst_rv", 64'(rv64), 64'd1);
    rst = 1; #1;
    chk("rst_async_rv64", 64'(rv64), 64'd0); chk("rst_async_rv32", 64'(rv32), 64'd0);
    chk("rst_async_rpc", rpc64, 64'd0);
    rd(12'h300); chk("rst_async_mstatus", rd64, 64'h1800);
    rd(12'h341); chk("rst_async_mepc", rd64, 64'd0);
    rst = 0;
    step();
    chk("post_rst_rv", 64'(rv64), 64'd0);

    // 64-bit counter wrap
    wr(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(12'hB00); chk("mcycle_max", rd64, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    rd(12'hB00); chk("mcycle_wrap64", rd64, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
